// File: rtl/simple_register_4b.sv
// 4-bit parallel-load register: four independent D flip-flops sharing clk and a
// synchronous active-high reset. Every rising edge captures all four data bits.
module simple_register_4b #(
    parameter logic [3:0] RESET_VALUE = 4'b0000
) (
    input  logic clk,
    input  logic rst,
    input  logic d0,
    input  logic d1,
    input  logic d2,
    input  logic d3,
    output logic q0,
    output logic q1,
    output logic q2,
    output logic q3
);

    localparam int unsigned WIDTH = 4;

    logic [WIDTH-1:0] d_bus;
    logic [WIDTH-1:0] q_reg;

    assign d_bus = {d3, d2, d1, d0};

    // Reset is only sampled on the clock edge; d is ignored on a reset edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_reg <= RESET_VALUE;
        end else begin
            q_reg <= d_bus;
        end
    end

    assign q0 = q_reg[0];
    assign q1 = q_reg[1];
    assign q2 = q_reg[2];
    assign q3 = q_reg[3];

endmodule

// File: tb/tb_simple_register_4b.sv
// Directed bench for simple_register_4b: reset, load/hold, edge race, independent
// toggles, mid-run reset, stopped clock and back-to-back loads.
module tb_simple_register_4b;

    logic clk;
    logic clk_en;
    logic rst;
    logic d0, d1, d2, d3;
    logic q0, q1, q2, q3;

    int checks;
    int errors;

    simple_register_4b #(.RESET_VALUE(4'b0000)) dut (
        .clk(clk),
        .rst(rst),
        .d0(d0),
        .d1(d1),
        .d2(d2),
        .d3(d3),
        .q0(q0),
        .q1(q1),
        .q2(q2),
        .q3(q3)
    );

    // Period 2: rising edges at t = 1, 3, 5, ...; clk_en=0 freezes the clock.
    initial begin
        clk = 1'b0;
        forever begin
            #1;
            if (clk_en) clk = ~clk;
        end
    end

    function automatic logic [3:0] q_now();
        return {q3, q2, q1, q0};
    endfunction

    task automatic drive_d(input logic [3:0] v);
        {d3, d2, d1, d0} = v;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (q_now() !== 4'b0000) begin
            errors++;
            $display("FAIL reset: q=%b expected=%b", q_now(), 4'b0000);
        end
    endtask

    task automatic test_load_hold();
        rst = 1'b0;
        drive_d(4'b1010);
        @(negedge clk);
        checks++;
        if (q_now() !== 4'b1010) begin
            errors++;
            $display("FAIL load: q=%b expected=%b", q_now(), 4'b1010);
        end
        // d moves between edges; q must not follow until the next rising edge.
        drive_d(4'b0101);
        #0;
        checks++;
        if (q_now() !== 4'b1010) begin
            errors++;
            $display("FAIL hold: q=%b expected=%b", q_now(), 4'b1010);
        end
        @(negedge clk);
        checks++;
        if (q_now() !== 4'b0101) begin
            errors++;
            $display("FAIL reload: q=%b expected=%b", q_now(), 4'b0101);
        end
    endtask

    task automatic test_edge_race();
        drive_d(4'b0000);
        @(negedge clk);
        checks++;
        if (q_now() !== 4'b0000) begin
            errors++;
            $display("FAIL race_setup: q=%b expected=%b", q_now(), 4'b0000);
        end
        // Nonblocking so d0 changes in the same timestep as the edge, after sampling.
        @(posedge clk);
        d0 <= 1'b1;
        @(negedge clk);
        checks++;
        if (q0 !== 1'b0) begin
            errors++;
            $display("FAIL race_old_value: q0=%b expected=%b", q0, 1'b0);
        end
        @(negedge clk);
        checks++;
        if (q0 !== 1'b1) begin
            errors++;
            $display("FAIL race_next_edge: q0=%b expected=%b", q0, 1'b1);
        end
    endtask

    task automatic test_independent_toggles();
        logic [3:0] expected;
        drive_d(4'b0000);
        fork
            for (int i = 0; i < 5; i++) begin #2; d0 <= ~d0; end
            for (int i = 0; i < 3; i++) begin #3; d1 <= ~d1; end
            for (int i = 0; i < 2; i++) begin #4; d2 <= ~d2; end
            for (int i = 0; i < 2; i++) begin #5; d3 <= ~d3; end
            for (int e = 0; e < 5; e++) begin
                @(posedge clk);
                expected = {d3, d2, d1, d0};
                @(negedge clk);
                checks++;
                if (q_now() !== expected) begin
                    errors++;
                    $display("FAIL toggle_edge%0d: q=%b expected=%b", e, q_now(), expected);
                end
            end
        join
    endtask

    task automatic test_midrun_reset();
        @(negedge clk);
        drive_d(4'b1111);
        @(negedge clk);
        checks++;
        if (q_now() !== 4'b1111) begin
            errors++;
            $display("FAIL midrun_preload: q=%b expected=%b", q_now(), 4'b1111);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (q_now() !== 4'b0000) begin
            errors++;
            $display("FAIL midrun_reset: q=%b expected=%b", q_now(), 4'b0000);
        end
        rst = 1'b0;
        drive_d(4'b0101);
        @(negedge clk);
        checks++;
        if (q_now() !== 4'b0101) begin
            errors++;
            $display("FAIL midrun_release: q=%b expected=%b", q_now(), 4'b0101);
        end
    endtask

    task automatic test_clock_stopped();
        drive_d(4'b0110);
        @(negedge clk);
        checks++;
        if (q_now() !== 4'b0110) begin
            errors++;
            $display("FAIL stop_preload: q=%b expected=%b", q_now(), 4'b0110);
        end
        clk_en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            drive_d(~{d3, d2, d1, d0});
            #1;
            checks++;
            if (q_now() !== 4'b0110) begin
                errors++;
                $display("FAIL stop_step%0d: q=%b expected=%b", i, q_now(), 4'b0110);
            end
        end
        clk_en = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [3:0] vecs [6];
        vecs = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b1111, 4'b0000};
        for (int i = 0; i < 6; i++) begin
            drive_d(vecs[i]);
            @(negedge clk);
            checks++;
            if (q_now() !== vecs[i]) begin
                errors++;
                $display("FAIL b2b_%0d: q=%b expected=%b", i, q_now(), vecs[i]);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        clk_en = 1'b1;
        rst = 1'b1;
        {d3, d2, d1, d0} = 4'b1111;
        test_reset();
        test_load_hold();
        test_edge_race();
        test_independent_toggles();
        test_midrun_reset();
        test_clock_stopped();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
